// File: rtl/rrmux_pkg.sv
// +---------------------------------------------------------------------------+
// | rrmux_pkg : shared constants and helpers for the rr_arb_mux selector      |
// | Revision  : 1.0                                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

package rrmux_pkg;

  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   TAM_DEFAULT = 16;

  // Ceiling log2 for tools that lack $clog2 in constant expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +---------------------------------------------------------------------------+
// | rr_arbiter : combinational grant logic (fixed select or round-robin)      |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import rrmux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = (N < 2) ? 1 : clog2(N)
) (
  input  logic [N-1:0]     in_valid_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] gnt_o,
  output logic             grant_valid_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  int             jsel;
  int             gidx;

  always_comb begin
    gnt_o         = '0;
    grant_valid_o = 1'b0;
    dbl           = '0;
    rot           = '0;
    found         = 1'b0;
    jsel          = 0;
    gidx          = 0;
    if (mode_i == MODE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if ((SEL_W'(i) == sel_i) && in_valid_i[i]) begin
          gnt_o         = SEL_W'(i);
          grant_valid_o = 1'b1;
        end
      end
    end else begin
      // Rotate so bit 0 is channel ptr+1; the lowest set bit is the winner.
      dbl = {in_valid_i, in_valid_i} >> (int'(ptr_i) + 1);
      rot = dbl[N-1:0];
      for (int j = N - 1; j >= 0; j--) begin
        if (rot[j]) begin
          found = 1'b1;
          jsel  = j;
        end
      end
      if (found) begin
        gidx = int'(ptr_i) + 1 + jsel;
        if (gidx >= N) gidx = gidx - N;
        gnt_o         = SEL_W'(gidx);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// +---------------------------------------------------------------------------+
// | rr_arb_mux : N-channel registered selector, valid/ready, fixed or RR      |
// | Option     : RRMUX_PARITY_EN adds registered out_par = ^out_data          |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module rr_arb_mux
  import rrmux_pkg::*;
#(
  parameter int TAM   = TAM_DEFAULT,
  parameter int N     = 4,
  parameter int SEL_W = (N < 2) ? 1 : clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*TAM-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [TAM-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef RRMUX_PARITY_EN
  output logic             out_par,
`endif
  output logic [SEL_W-1:0] out_ch
);

  logic [SEL_W-1:0] gnt;
  logic             grant_valid;
  logic             load;
  logic             xfer;
  logic [TAM-1:0]   sel_data;

  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [SEL_W-1:0] ch_q,    ch_d;
  logic [TAM-1:0]   data_q,  data_d;
  logic             valid_q, valid_d;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .in_valid_i    (in_valid),
    .ptr_i         (ptr_q),
    .mode_i        (mode),
    .sel_i         (sel),
    .gnt_o         (gnt),
    .grant_valid_o (grant_valid)
  );

  assign load = !valid_q || out_ready;
  // rst_n gates the accept so no producer sees a handshake while in reset.
  assign xfer = rst_n && load && grant_valid;

  for (genvar i = 0; i < N; i++) begin : g_ready
    assign in_ready[i] = xfer && (gnt == SEL_W'(i));
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SEL_W'(i)) sel_data = in_data[i*TAM +: TAM];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      if (xfer) begin
        data_d  = sel_data;
        ch_d    = gnt;
        valid_d = 1'b1;
        if (mode == MODE_RR) ptr_d = gnt;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= SEL_W'(N - 1);
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_ch    = ch_q;

`ifdef RRMUX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (xfer) par_d = ^sel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// +---------------------------------------------------------------------------+
// | tb_rr_arb_mux : self-checking bench for rr_arb_mux (N=4, TAM=16)          |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_rr_arb_mux;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] rdy;
  } vec_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
`ifdef RRMUX_PARITY_EN
  logic        out_par;
`endif

  int total = 0;
  int bad   = 0;

  sb_t         sb_q[$];
  logic        exp_valid = 1'b0;
  logic [15:0] exp_data  = '0;
  logic [1:0]  exp_ch    = '0;

  vec_t vecs[20];

  rr_arb_mux #(
    .TAM (16),
    .N   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RRMUX_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int k);
    for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'hC000 | 16'(k << 4) | 16'(i);
  endtask

  // Entered just after a falling edge; returns on the next falling edge.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic ordy, input logic [3:0] rdy);
    logic exp_load;
    int   g;
    sb_t  e;
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    g = 0;
    for (int i = 0; i < 4; i++) if (rdy[i]) g = i;
    if (rdy != 4'b0000) begin
      e.ch   = 2'(g);
      e.data = in_data[g*16 +: 16];
      sb_q.push_back(e);
    end
    exp_load = !exp_valid || ordy;
    @(posedge clk);
    #1;
    if (rdy != 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        exp_valid = 1'b1;
        exp_data  = e.data;
        exp_ch    = e.ch;
      end
    end else if (exp_load) begin
      exp_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_ch", 32'(out_ch), 32'(exp_ch));
`ifdef RRMUX_PARITY_EN
      chk("out_par", 32'(out_par), 32'(^exp_data));
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    // mode, sel, valid, out_ready, expected in_ready (ptr carried across rows)
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[8]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[9]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
    vecs[10] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100};
    vecs[11] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001};
    vecs[12] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010};
    vecs[13] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010};
    vecs[14] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[15] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010};
    vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};

    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_ch", 32'(out_ch), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
`ifdef RRMUX_PARITY_EN
    chk("reset_out_par", 32'(out_par), 32'd0);
`endif
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      set_data(k);
      if (k == 8) in_data[2*16 +: 16] = 16'hA5A5;
      step(vecs[k].mode, vecs[k].sel, vecs[k].valid, vecs[k].ordy, vecs[k].rdy);
    end

    // Backpressure: 16'h1234 must survive three stalled cycles, ptr stays at 0.
    set_data(30);
    in_data[0*16 +: 16] = 16'h1234;
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      set_data(31 + k);
      step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
      chk("stall_hold_1234", 32'(out_data), 32'h1234);
    end
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);

    // Fixed select of a non-valid channel: held word drains, nothing new.
    step(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000);
    step(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000);

    set_data(40);
    in_data[2*16 +: 16] = 16'h0007;
    step(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100);
`ifdef RRMUX_PARITY_EN
    chk("parity_0007", 32'(out_par), 32'd1);
`endif

    // Asynchronous reset between clock edges while a word is held.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    exp_valid = 1'b0; exp_data = '0; exp_ch = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_data(50);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
    step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, TAM-bit data selector with a registered output and a valid/ready handshake on every port.
- Successor to the combinational 4:1 selector.
- Two selection modes:
  - fixed-select, driven by a `sel` input;
  - round-robin arbitration among the valid channels.
- Sits between multiple NRISC producers (register-file ports, bus masters) and one shared consumer.

Parameters:
- TAM, 16, data width of each channel.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N), width of the channel index.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_data  in  N*TAM  channel i is at [i*TAM +: TAM].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel accept, combinational.
- out_data  out  TAM  registered selected word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_ch  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority.
  - Reset mid-transfer discards the held word; no in_ready is asserted while rst_n=0.
- Load condition: `load = !out_valid || out_ready`. This gives a single-stage pipeline with full throughput of 1 word/cycle.
- Grant selection, mode=0 (fixed):
  - gnt = sel if in_valid[sel].
  - If sel >= N, no grant.
- Grant selection, mode=1 (round-robin):
  - Search channels ptr+1, ptr+2, ... wrapping modulo N; the first with in_valid=1 wins.
  - If no channel is valid, no grant.
- Handshake:
  - in_ready[i] = load && grant_valid && gnt==i. This is one-hot or zero.
  - A transfer occurs on channel i when in_valid[i] && in_ready[i].
- Register update on a clock edge with a transfer:
  - out_data <= in_data[gnt]; out_ch <= gnt; out_valid <= 1.
  - When mode=1, ptr <= gnt.
- Register update with load true but no grant: out_valid <= 0; out_data and out_ch hold.
- Register update with load false (stall): all output registers hold.
  - The ptr never moves on a stall or a non-granted cycle.
  - ptr is not updated by mode=0 transfers.
- Latency: 1 cycle from input transfer to out_valid.
- Back-to-back: if out_valid && out_ready and a new grant exists in the same cycle, the new word replaces the old one with no bubble.
- A mode or sel change takes effect at the next grant evaluation; a word already held is unaffected.
- Single valid channel in RR mode is granted every cycle; this is the wrap-around case where ptr==gnt.
- With N=1, SEL_W is forced to 1 and the block degenerates to a one-entry pipeline register.

Optional Feature:
- Macro: RRMUX_PARITY_EN.
- Defined:
  - Adds output `out_par` (1 bit) = ^out_data, registered in the same cycle as out_data.
  - Reset value of out_par is 0.
- Undefined: no out_par port and no parity logic; behaviour is otherwise identical.

Decomposition:
- Package rrmux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a localparam default for TAM=16;
  - a clog2 helper function for tools without $clog2.
- One natural sub-module, rr_arbiter. It takes in_valid, ptr, mode and sel, and produces gnt and grant_valid.
  - It is purely combinational.
  - ptr stays in the parent, so the top level holds all state.

Test Plan:
- Reset check: hold rst_n=0 with all in_valid=1.
  - Required: out_valid=0, out_data=0, in_ready=0.
  - Release reset with mode=1: first grant is channel 0, in_ready=4'b0001.
- Fixed mode: mode=0, sel=2, in_data ch2=16'hA5A5, in_valid=4'b1111.
  - Required: in_ready=4'b0100, and next cycle out_data=16'hA5A5, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, all four channels valid for 8 cycles, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Backpressure:
  - Drive out_ready=0 with out_valid=1 holding 16'h1234. Required: in_ready=0, and out_data stays 16'h1234 for 3 cycles with ptr unchanged.
  - Raise out_ready. Required: the next RR channel is loaded that same cycle.
- Sparse requests and wrap: ptr=3, in_valid=4'b0100.
  - Required: grant ch2.
  - Then in_valid=4'b0101. Required: grant ch0, since the search order after 2 is 3, 0.
- Invalid select and async reset mid-stream:
  - mode=0, sel=3 with in_valid[3]=0. Required: no in_ready, and out_valid drops after the consumer takes the held word.
  - Assert rst_n=0 mid-cycle while out_valid=1. Required: out_valid=0 immediately, without waiting for a clock edge.
  - With RRMUX_PARITY_EN defined and out_data=16'h0007, required: out_par=1.
